// File: rtl/op1_pkg.sv
// Shared constants, FSM state type and activation-bus packing for the op1 sequencer.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package op1_pkg;

    localparam int N_IN   = 32;
    localparam int DATA_W = 4;
    localparam int SUM_W  = 9;
    localparam int CNT_W  = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        WAITW,
        SETTLE,
        OUT
    } state_t;

    typedef logic [DATA_W-1:0] act_bank_t [N_IN];

    // Slot k lands on bits [4k+3:4k] of the op1 data bus.
    function automatic logic [N_IN*DATA_W-1:0] pack_acts(input act_bank_t bank);
        logic [N_IN*DATA_W-1:0] flat;
        flat = '0;
        for (int k = 0; k < N_IN; k++) begin
            flat[k*DATA_W +: DATA_W] = bank[k];
        end
        return flat;
    endfunction

endpackage

// File: rtl/op1_seq_if.sv
// Bundle of the sequencer's control, activation, ROM, op1 and result signals.
// Latency: n/a (wires only).
// Backpressure: res stream is valid/ready; activation stream is ready only in LOAD.
interface op1_seq_if #(
    parameter int IDX_W = 4
) ();
    import op1_pkg::*;

    logic                     start_in;
    logic                     busy_out;
    logic                     done_out;
    logic                     act_valid_in;
    logic                     act_ready_out;
    logic [DATA_W-1:0]        act_data_in;
    logic                     w_rd_out;
    logic [IDX_W-1:0]         w_addr_out;
    logic [N_IN-1:0]          w_data_in;
    logic [N_IN*DATA_W-1:0]   op_data_out;
    logic [N_IN-1:0]          op_inv_out;
    logic [SUM_W-1:0]         op_result_in;
    logic                     res_valid_out;
    logic                     res_ready_in;
    logic [SUM_W-1:0]         res_data_out;
    logic [IDX_W-1:0]         res_idx_out;

    // Sequencer side.
    modport master (
        input  start_in, act_valid_in, act_data_in, w_data_in, op_result_in, res_ready_in,
        output busy_out, done_out, act_ready_out, w_rd_out, w_addr_out,
               op_data_out, op_inv_out, res_valid_out, res_data_out, res_idx_out
    );

    // Environment side: activation source, weight ROM, op1 adder, result sink.
    modport slave (
        output start_in, act_valid_in, act_data_in, w_data_in, op_result_in, res_ready_in,
        input  busy_out, done_out, act_ready_out, w_rd_out, w_addr_out,
               op_data_out, op_inv_out, res_valid_out, res_data_out, res_idx_out
    );

endinterface

// File: rtl/op1_popcnt.sv
// Population count of a 32-bit inversion word.
// Latency: combinational.
// Backpressure: none.
module op1_popcnt (
    input  logic [31:0] vec_i,
    output logic [5:0]  cnt_o
);

    // Straight adder chain; synthesis folds it into a compressor tree.
    always_comb begin
        cnt_o = '0;
        for (int k = 0; k < 32; k++) begin
            cnt_o = cnt_o + {5'd0, vec_i[k]};
        end
    end

endmodule

// File: rtl/op1_seq.sv
// Sequences the 32-input op1 adder: loads activations, then per neuron fetches inv word, settles, emits sum.
// Latency: first result SETTLE_CYC+2 cycles after the 32nd beat; SETTLE_CYC+3 cycles per neuron with ready high.
// Backpressure: result held in OUT until res_ready_in; activations accepted only in LOAD. Macro OP1_CORR_EN adds popcount correction.
module op1_seq
    import op1_pkg::*;
#(
    parameter int NUM_OUT    = 16,
    parameter int IDX_W      = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic     clock,
    input  logic     reset_n,
    op1_seq_if.master bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    act_bank_t          bank_q;
    logic [N_IN-1:0]    inv_q;
    logic [IDX_W-1:0]   idx_q;
    logic [3:0]         settle_q;
    logic               res_vld_q;
    logic [SUM_W-1:0]   res_dat_q;
    logic [IDX_W-1:0]   res_idx_q;
    logic               done_q;

    logic               beat;
    logic               last_beat;
    logic               res_hs;
    logic               last_idx;
    logic               settle_end;
    logic [SUM_W-1:0]   capt_dat;

    assign beat       = (state_q == LOAD) && bus.act_valid_in;
    assign last_beat  = beat && (cnt_q == CNT_W'(N_IN - 1));
    // res_vld_q is high for the whole of OUT, so state alone qualifies the handshake.
    assign res_hs     = (state_q == OUT) && bus.res_ready_in;
    assign last_idx   = (idx_q == IDX_W'(NUM_OUT - 1));
    assign settle_end = (state_q == SETTLE) && (settle_q <= 4'd1);

`ifdef OP1_CORR_EN
    logic [5:0] inv_pop;

    op1_popcnt u_popcnt (
        .vec_i (inv_q),
        .cnt_o (inv_pop)
    );

    // Each inverted input contributed ~x = -x-1; adding the popcount turns it into -x.
    assign capt_dat = bus.op_result_in + SUM_W'(inv_pop);
`else
    assign capt_dat = bus.op_result_in;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_in) state_d = LOAD;
            LOAD:    if (last_beat)    state_d = FETCH;
            FETCH:                     state_d = WAITW;
            WAITW:                     state_d = SETTLE;
            SETTLE:  if (settle_end)   state_d = OUT;
            OUT:     if (res_hs)       state_d = last_idx ? IDLE : FETCH;
            default:                   state_d = IDLE;
        endcase
    end

    // Datapath: activation bank, inversion word, counters and the result holding registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            inv_q     <= '0;
            idx_q     <= '0;
            settle_q  <= '0;
            res_vld_q <= 1'b0;
            res_dat_q <= '0;
            res_idx_q <= '0;
            done_q    <= 1'b0;
            for (int k = 0; k < N_IN; k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_in) cnt_q <= '0;
                end
                LOAD: begin
                    if (beat) begin
                        bank_q[cnt_q] <= bus.act_data_in;
                        cnt_q         <= cnt_q + 1'b1;
                        if (last_beat) idx_q <= '0;
                    end
                end
                WAITW: begin
                    // ROM data is valid exactly one cycle after the read strobe.
                    inv_q    <= bus.w_data_in;
                    settle_q <= 4'(SETTLE_CYC);
                end
                SETTLE: begin
                    settle_q <= settle_q - 1'b1;
                    if (settle_end) begin
                        res_vld_q <= 1'b1;
                        res_dat_q <= capt_dat;
                        res_idx_q <= idx_q;
                    end
                end
                OUT: begin
                    if (res_hs) begin
                        res_vld_q <= 1'b0;
                        if (last_idx) done_q <= 1'b1;
                        else          idx_q  <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_out      = (state_q != IDLE);
    assign bus.act_ready_out = (state_q == LOAD);
    assign bus.w_rd_out      = (state_q == FETCH);
    assign bus.w_addr_out    = idx_q;
    assign bus.op_data_out   = pack_acts(bank_q);
    assign bus.op_inv_out    = inv_q;
    assign bus.res_valid_out = res_vld_q;
    assign bus.res_data_out  = res_dat_q;
    assign bus.res_idx_out   = res_idx_q;
    assign bus.done_out      = done_q;

endmodule

// File: tb/tb_op1_seq.sv
// Testbench for op1_seq: ROM and op1 adder models around the DUT, result scoreboard, directed runs.
// Latency: n/a.
// Backpressure: bench stalls res_ready_in on chosen neurons.
module tb_op1_seq;

    localparam int NUM_OUT    = 16;
    localparam int IDX_W      = 4;
    localparam int SETTLE_CYC = 2;

    logic clock;
    logic reset_n;

    op1_seq_if #(.IDX_W(IDX_W)) bus ();

    op1_seq #(
        .NUM_OUT    (NUM_OUT),
        .IDX_W      (IDX_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [8:0]       dat;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    int          acts [32];
    logic [31:0] rom [NUM_OUT];
    exp_t        expq [$];
    logic        done_pend = 1'b0;
    int          hs_cnt = 0;
    int          env_acc;
    logic [3:0]  env_nib;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected result for neuron n from the loaded activations and ROM word.
    function automatic logic [8:0] model_sum(input int n);
        int s;
        s = 0;
        for (int k = 0; k < 32; k++) begin
            s += rom[n][k] ? (15 - acts[k]) : acts[k];
        end
`ifdef OP1_CORR_EN
        s += $countones(rom[n]);
`endif
        return 9'(s % 512);
    endfunction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Weight ROM: data presented one cycle after the strobe, junk otherwise.
    always @(posedge clock) begin
        if (bus.w_rd_out) bus.w_data_in <= rom[bus.w_addr_out];
        else              bus.w_data_in <= 32'hDEAD_BEEF;
    end

    // External op1 adder: sums held activations, inverting those flagged in the inv word.
    always_comb begin
        env_acc = 0;
        env_nib = '0;
        for (int k = 0; k < 32; k++) begin
            env_nib = bus.op_data_out[4*k +: 4];
            if (bus.op_inv_out[k]) env_acc = env_acc + (15 - int'(env_nib));
            else                   env_acc = env_acc + int'(env_nib);
        end
    end
    assign bus.op_result_in = env_acc[8:0];

    // Scoreboard: every valid cycle must show the queue head; done must follow the last accept.
    always @(negedge clock) begin
        if (!reset_n) begin
            done_pend = 1'b0;
        end else begin
            check("done_out", bus.done_out, done_pend);
            done_pend = 1'b0;
            if (bus.res_valid_out) begin
                if (expq.size() == 0) begin
                    check("unexpected_res_valid", bus.res_valid_out, 1'b0);
                end else begin
                    check("res_data", bus.res_data_out, expq[0].dat);
                    check("res_idx", bus.res_idx_out, expq[0].idx);
                    if (bus.res_ready_in) begin
                        hs_cnt++;
                        if (int'(expq[0].idx) == NUM_OUT - 1) done_pend = 1'b1;
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    task automatic outputs_zero(input string tag);
        check({tag, "_busy"},      bus.busy_out, 0);
        check({tag, "_done"},      bus.done_out, 0);
        check({tag, "_act_ready"}, bus.act_ready_out, 0);
        check({tag, "_w_rd"},      bus.w_rd_out, 0);
        check({tag, "_w_addr"},    bus.w_addr_out, 0);
        check({tag, "_op_data"},   bus.op_data_out, 0);
        check({tag, "_op_inv"},    bus.op_inv_out, 0);
        check({tag, "_res_valid"}, bus.res_valid_out, 0);
        check({tag, "_res_data"},  bus.res_data_out, 0);
        check({tag, "_res_idx"},   bus.res_idx_out, 0);
    endtask

    // Start a run and stream the 32 activations, inserting an idle gap every 'gaps' beats.
    task automatic load_acts(input int gaps);
        @(posedge clock); #1 bus.start_in = 1'b1;
        @(posedge clock); #1 bus.start_in = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (gaps > 0 && (k % gaps) == 1) begin
                bus.act_valid_in = 1'b0;
                bus.act_data_in  = 4'(15 - acts[k]);
                @(posedge clock); #1;
            end
            bus.act_valid_in = 1'b1;
            bus.act_data_in  = 4'(acts[k]);
            check("act_ready", bus.act_ready_out, 1);
            @(posedge clock); #1;
        end
        bus.act_valid_in = 1'b0;
    endtask

    task automatic run(input int gaps, input int bp_idx, input int start_at,
                       input int lit_idx, input int lit_val);
        int lat;
        int hs0;
        for (int n = 0; n < NUM_OUT; n++) begin
            expq.push_back('{idx: IDX_W'(n), dat: model_sum(n)});
        end
        hs0 = hs_cnt;
        bus.res_ready_in = (bp_idx != 0);
        load_acts(gaps);
        lat = 0;
        while (!bus.res_valid_out && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        check("first_latency", lat, SETTLE_CYC + 2);
        for (int n = 0; n < NUM_OUT; n++) begin
            int w;
            w = 0;
            while (!bus.res_valid_out && w < 50) begin
                @(posedge clock); #1;
                w++;
            end
            check("res_valid_wait", bus.res_valid_out, 1);
            if (n == lit_idx) check("literal_sum", bus.res_data_out, lit_val);
            if (n == bp_idx) begin
                repeat (10) begin @(posedge clock); #1; end
                check("bp_valid_held", bus.res_valid_out, 1);
                check("bp_idx_held", bus.res_idx_out, n);
                check("bp_data_held", bus.res_data_out, model_sum(n));
                check("bp_no_accept", hs_cnt - hs0, n);
                bus.res_ready_in = 1'b1;
            end
            if (n == start_at) bus.start_in = 1'b1;
            @(posedge clock); #1;
            bus.start_in = 1'b0;
            if (n + 1 == bp_idx) bus.res_ready_in = 1'b0;
        end
        check("end_busy", bus.busy_out, 0);
        check("hs_count", hs_cnt - hs0, NUM_OUT);
        check("queue_empty", expq.size(), 0);
        @(posedge clock); #1;
        check("idle_busy", bus.busy_out, 0);
        check("idle_act_ready", bus.act_ready_out, 0);
    endtask

    task automatic reset_mid_settle();
        int w;
        w = 0;
        bus.res_ready_in = 1'b1;
        load_acts(0);
        while (!bus.w_rd_out && w < 20) begin
            @(posedge clock); #1;
            w++;
        end
        check("rst_fetch_seen", bus.w_rd_out, 1);
        check("rst_fetch_busy", bus.busy_out, 1);
        // WAITW, then the first SETTLE cycle; assert reset between edges.
        @(posedge clock);
        @(posedge clock); #3;
        reset_n = 1'b0;
        expq.delete();
        #1 outputs_zero("midrst");
        @(posedge clock);
        @(posedge clock); #3;
        reset_n = 1'b1;
        repeat (15) begin
            @(posedge clock); #1;
            check("post_rst_busy", bus.busy_out, 0);
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.start_in     = 1'b0;
        bus.act_valid_in = 1'b0;
        bus.act_data_in  = '0;
        bus.res_ready_in = 1'b0;
        rom[0] = 32'h0000_0000;
        rom[1] = 32'hFFFF_FFFF;
        rom[2] = 32'h0000_FFFF;
        rom[3] = 32'hAAAA_AAAA;
        for (int n = 4; n < NUM_OUT; n++) rom[n] = $urandom;

        repeat (3) @(posedge clock);
        #1 outputs_zero("rst");
        #2 reset_n = 1'b1;
        @(posedge clock); #1;
        check("post_rst_idle_busy", bus.busy_out, 0);

        // Ramp activations 0..15,0..15: idx0 with no inversion sums to 240.
        for (int k = 0; k < 32; k++) acts[k] = k % 16;
        run(0, 2, -1, 0, 240);

        // All-zero activations, idx1 fully inverted: 32*15 = 480 raw, wraps to 0 when corrected.
        for (int k = 0; k < 32; k++) acts[k] = 0;
`ifdef OP1_CORR_EN
        run(3, 5, 3, 1, 0);
`else
        run(3, 5, 3, 1, 480);
`endif

        for (int k = 0; k < 32; k++) acts[k] = int'($urandom_range(1, 15));
        reset_mid_settle();

        for (int k = 0; k < 32; k++) acts[k] = int'($urandom_range(0, 15));
        run(2, NUM_OUT - 1, 7, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
